// File: rtl/approx_mult_pkg.sv
// Shared types and constants for the 8x8 approximate multiplier characterisation blocks.
package approx_mult_pkg;
  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

  typedef logic [PROD_W-1:0] ed_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mon_state_e;
endpackage

// File: rtl/approx_ed_calc.sv
// Combinational error distance |x*y - z_approx| of one approximate product against the exact one.
module approx_ed_calc
  import approx_mult_pkg::*;
(
  input  logic [OP_W-1:0]   x,
  input  logic [OP_W-1:0]   y,
  input  logic [PROD_W-1:0] z_approx,
  output logic [PROD_W-1:0] ed
);

  logic [PROD_W-1:0] exact;

  always_comb begin
    exact = PROD_W'(x) * PROD_W'(y);
    ed    = (exact >= z_approx) ? (exact - z_approx) : (z_approx - exact);
  end

endmodule

// File: rtl/approx_mult_error_monitor.sv
// Accumulates ED sum / max / error count over N_SAMPLES accepted samples (2-stage pipeline).
// Build with WORST_CAPTURE_EN to also record the operand pair of the first max-ED sample.
module approx_mult_error_monitor
  import approx_mult_pkg::*;
#(
  parameter  int N_SAMPLES = 256,
  localparam int CNT_W     = $clog2(N_SAMPLES + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [OP_W-1:0]         x,
  input  logic [OP_W-1:0]         y,
  input  logic [PROD_W-1:0]       z_approx,
  output logic                    busy,
  output logic                    done,
  output logic [PROD_W+CNT_W-1:0] sum_ed,
  output logic [PROD_W-1:0]       max_ed,
  output logic [CNT_W-1:0]        err_cnt,
  output logic [OP_W-1:0]         worst_x,
  output logic [OP_W-1:0]         worst_y
);

  localparam int               SUM_W = PROD_W + CNT_W;
  localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N_SAMPLES);

  mon_state_e       state, state_next;
  logic [CNT_W-1:0] acc_cnt;
  logic             accept;
  logic             start_ok;
  logic             s1_valid;
  ed_t              s1_ed;
  ed_t              ed_comb;
  logic             new_max;

  assign in_ready = (state == RUN) && (acc_cnt < N_CNT);
  assign accept   = in_valid && in_ready;
  assign start_ok = start && (state != RUN);
  assign busy     = (state == RUN);
  assign done     = (state == DONE);
  assign new_max  = s1_valid && (s1_ed > max_ed);

  approx_ed_calc u_ed_calc (
    .x        (x),
    .y        (y),
    .z_approx (z_approx),
    .ed       (ed_comb)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // RUN only ends once the last accepted sample has drained out of stage 1.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if ((acc_cnt == N_CNT) && !s1_valid) state_next = DONE;
      DONE:    if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt  <= '0;
      s1_valid <= 1'b0;
      s1_ed    <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) s1_ed <= ed_comb;
      if (start_ok)    acc_cnt <= '0;
      else if (accept) acc_cnt <= acc_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      sum_ed  <= '0;
      max_ed  <= '0;
      err_cnt <= '0;
    end else if (s1_valid) begin
      sum_ed <= sum_ed + SUM_W'(s1_ed);
      if (s1_ed != '0) err_cnt <= err_cnt + CNT_W'(1);
      if (new_max)     max_ed  <= s1_ed;
    end
  end

`ifdef WORST_CAPTURE_EN
  logic [OP_W-1:0] s1_x, s1_y;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_x <= '0;
      s1_y <= '0;
    end else if (accept) begin
      s1_x <= x;
      s1_y <= y;
    end
  end

  // Strict compare in new_max keeps the first occurrence on ties.
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      worst_x <= '0;
      worst_y <= '0;
    end else if (new_max) begin
      worst_x <= s1_x;
      worst_y <= s1_y;
    end
  end
`else
  assign worst_x = '0;
  assign worst_y = '0;
`endif

endmodule

// File: tb/tb_approx_mult_error_monitor.sv
// Directed bench for approx_mult_error_monitor with a transaction-level reference model.
module tb_approx_mult_error_monitor;
  localparam int NS    = 4;
  localparam int CNT_W = $clog2(NS + 1);

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic                in_valid = 1'b0;
  logic [7:0]          x = '0;
  logic [7:0]          y = '0;
  logic [15:0]         z_approx = '0;
  logic                in_ready, busy, done;
  logic [16+CNT_W-1:0] sum_ed;
  logic [15:0]         max_ed;
  logic [CNT_W-1:0]    err_cnt;
  logic [7:0]          worst_x, worst_y;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  // Reference model: list of accepted samples tagged with the edge they were accepted on.
  int m_e[$], m_x[$], m_y[$], m_ed[$];
  bit m_active = 1'b0;
  int ecnt = 0;

  approx_mult_error_monitor #(.N_SAMPLES(NS)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .y        (y),
    .z_approx (z_approx),
    .busy     (busy),
    .done     (done),
    .sum_ed   (sum_ed),
    .max_ed   (max_ed),
    .err_cnt  (err_cnt),
    .worst_x  (worst_x),
    .worst_y  (worst_y)
  );

  always #5 clk = ~clk;

  function automatic int wexp(input int v);
`ifdef WORST_CAPTURE_EN
    return v;
`else
    return 0;
`endif
  endfunction

  function automatic bit mdone();
    if (!m_active) return 1'b0;
    if (m_e.size() != NS) return 1'b0;
    return (ecnt - m_e[NS-1]) >= 2;
  endfunction

  function automatic bit mbusy();
    return m_active && !mdone();
  endfunction

  function automatic bit mready();
    return mbusy() && (m_e.size() < NS);
  endfunction

  // Statistics visible now: samples accepted on an earlier edge than the latest one.
  task automatic mstats(output int s, output int mx, output int er, output int wx, output int wy);
    s = 0; mx = 0; er = 0; wx = 0; wy = 0;
    foreach (m_e[i]) begin
      if (m_e[i] < ecnt) begin
        s += m_ed[i];
        if (m_ed[i] != 0) er++;
        if (m_ed[i] > mx) begin
          mx = m_ed[i]; wx = m_x[i]; wy = m_y[i];
        end
      end
    end
  endtask

  task automatic mclear();
    m_e.delete(); m_x.delete(); m_y.delete(); m_ed.delete();
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  initial forever begin
    bit pb, pr;
    int p;
    @(posedge clk);
    pb = mbusy();
    pr = mready();
    ecnt++;
    if (rst) begin
      m_active = 1'b0;
      mclear();
    end else if (start && !pb) begin
      m_active = 1'b1;
      mclear();
    end else if (pr && in_valid) begin
      p = int'(x) * int'(y);
      m_e.push_back(ecnt);
      m_x.push_back(int'(x));
      m_y.push_back(int'(y));
      m_ed.push_back((p >= int'(z_approx)) ? p - int'(z_approx) : int'(z_approx) - p);
    end
  end

  initial forever begin
    int s, mx, er, wx, wy;
    @(negedge clk);
    if (chk_en) begin
      mstats(s, mx, er, wx, wy);
      check("in_ready", in_ready, mready());
      check("busy",     busy,     mbusy());
      check("done",     done,     mdone());
      check("sum_ed",   sum_ed,   s);
      check("max_ed",   max_ed,   mx);
      check("err_cnt",  err_cnt,  er);
      check("worst_x",  worst_x,  wexp(wx));
      check("worst_y",  worst_y,  wexp(wy));
    end
  end

  task automatic drive(input bit v, input int a, input int b, input int c, input bit st = 1'b0);
    in_valid = v; x = 8'(a); y = 8'(b); z_approx = 16'(c); start = st;
    @(negedge clk);
    in_valid = 1'b0; start = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 && !done; i++) @(negedge clk);
    check("wait_done", done, 1);
  endtask

  task automatic stats_lit(input string tag, input int s, input int mx, input int er,
                           input int wx, input int wy);
    check({tag, "_sum"},  sum_ed,  s);
    check({tag, "_max"},  max_ed,  mx);
    check({tag, "_err"},  err_cnt, er);
    check({tag, "_wx"},   worst_x, wexp(wx));
    check({tag, "_wy"},   worst_y, wexp(wy));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    stats_lit("rst", 0, 0, 0, 0, 0);

    // all-exact products, back to back; done exactly 2 cycles after last accept
    do_start();
    drive(1, 3, 5, 15);
    drive(1, 7, 9, 63);
    drive(1, 0, 255, 0);
    drive(1, 255, 255, 65025);
    check("t1_ready_after_last", in_ready, 0);
    check("t1_done_T0", done, 0);
    @(negedge clk);
    check("t1_done_T1", done, 0);
    @(negedge clk);
    check("t1_done_T2", done, 1);
    stats_lit("t1", 0, 0, 0, 0, 0);

    // mixed errors, including z above the exact product
    do_start();
    drive(1, 255, 255, 65020);
    drive(1, 2, 3, 8);
    drive(1, 4, 4, 16);
    drive(1, 1, 1, 1);
    wait_done();
    stats_lit("t2", 7, 5, 2, 255, 255);

    // start in DONE clears everything on the next cycle; gappy in_valid
    do_start();
    check("t3_busy", busy, 1);
    check("t3_done", done, 0);
    stats_lit("t3_clr", 0, 0, 0, 0, 0);
    drive(1, 1, 1, 2);
    drive(0, 200, 200, 0);
    drive(0, 200, 200, 0);
    drive(1, 2, 2, 6);
    drive(1, 3, 3, 12);
    drive(0, 200, 200, 0);
    drive(1, 5, 5, 29);
    check("t3_ready_after_4th", in_ready, 0);
    drive(1, 9, 9, 0);
    drive(1, 9, 9, 0);
    drive(1, 9, 9, 0);
    wait_done();
    stats_lit("t3", 10, 4, 4, 5, 5);

    // tie on max ED keeps the first occurrence
    do_start();
    drive(1, 10, 10, 94);
    drive(1, 20, 20, 394);
    drive(1, 1, 2, 2);
    drive(1, 3, 3, 9);
    wait_done();
    stats_lit("t4", 12, 6, 2, 10, 10);

    // start pulsed mid-run (alongside a valid sample) is ignored
    do_start();
    drive(1, 6, 6, 30);
    drive(1, 7, 7, 50, 1'b1);
    check("t5_busy_after_start", busy, 1);
    drive(1, 8, 8, 64);
    drive(1, 2, 2, 1);
    wait_done();
    stats_lit("t5", 10, 6, 3, 6, 6);

    // reset after 2 of 4 samples aborts the run, then a fresh run
    do_start();
    drive(1, 6, 6, 30);
    drive(1, 7, 7, 50);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_in_ready", in_ready, 0);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    stats_lit("t6_rst", 0, 0, 0, 0, 0);
    do_start();
    drive(1, 3, 3, 10);
    drive(1, 4, 4, 20);
    drive(1, 2, 2, 4);
    drive(1, 1, 1, 0);
    wait_done();
    stats_lit("t6", 6, 4, 3, 4, 4);

    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
